// File: rtl/uart_peripheral_if.sv
// Hardware-register port between the Lisp core and its memory-mapped peripherals.
interface uart_peripheral_if;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;

  modport master (
    output register_index,
    output register_read,
    output register_write,
    output register_write_value,
    input  register_read_value
  );

  modport slave (
    input  register_index,
    input  register_read,
    input  register_write,
    input  register_write_value,
    output register_read_value
  );
endinterface

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART on the core's hardware-register port: an 8-index
// register window, TX/RX FIFOs and one-cycle registered read data.
module uart_peripheral #(
  parameter int unsigned BASE_INDEX   = 0,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_peripheral_if.slave bus,
  output logic             uart_tx,
  input  logic             uart_rx
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  WINDOW    = 4'(BASE_INDEX / 8);
  localparam logic [15:0] DIV_RESET = 16'(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_TX_DATA = 3'd1,
    REG_RX_DATA = 3'd2,
    REG_RX_CTRL = 3'd3,
    REG_DIVISOR = 3'd4
  } reg_offset_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // ---------------------------------------------------------------- decode
  logic       in_window;
  logic [2:0] offset;
  logic       wr_hit;
  logic       tx_push_req;
  logic       rx_pop_req;
  logic       sticky_clear;
  logic       div_wr;

  assign in_window    = (bus.register_index[6:3] == WINDOW);
  assign offset       = bus.register_index[2:0];
  assign wr_hit       = bus.register_write && in_window;
  assign tx_push_req  = wr_hit && (offset == REG_TX_DATA);
  assign rx_pop_req   = wr_hit && (offset == REG_RX_CTRL) && bus.register_write_value[0];
  assign sticky_clear = wr_hit && (offset == REG_RX_CTRL) && bus.register_write_value[1];
  assign div_wr       = wr_hit && (offset == REG_DIVISOR);

  logic [15:0] divisor;

  // A divisor below 2 would leave no room for the half-bit RX start delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor <= DIV_RESET;
    end else if (div_wr) begin
      divisor <= (bus.register_write_value < 16'd2) ? 16'd2 : bus.register_write_value;
    end
  end

  // --------------------------------------------------------------- TX FIFO
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wptr;
  logic [AW:0] tx_rptr;
  logic        tx_empty;
  logic        tx_full;
  logic        tx_push;
  logic        tx_pop;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign tx_push  = tx_push_req && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr[AW-1:0]] <= bus.register_write_value[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_e   tx_state, tx_state_next;
  logic [15:0] tx_cnt, tx_cnt_next;
  logic [7:0]  tx_shift, tx_shift_next;
  logic [2:0]  tx_bit, tx_bit_next;
  logic        tx_line, tx_line_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_shift <= tx_shift_next;
      tx_bit   <= tx_bit_next;
      tx_line  <= tx_line_next;
    end
  end

  // Line level is registered alongside the state so each bit holds for exactly
  // one full counter period starting on the edge that enters it.
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_shift_next = tx_shift;
    tx_bit_next   = tx_bit;
    tx_line_next  = tx_line;
    tx_pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_next = 1'b1;
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = tx_mem[tx_rptr[AW-1:0]];
          tx_cnt_next   = divisor;
          tx_line_next  = 1'b0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt <= 16'd1) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = divisor;
          tx_bit_next   = '0;
          tx_line_next  = tx_shift[0];
        end else begin
          tx_cnt_next = tx_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt <= 16'd1) begin
          tx_cnt_next = divisor;
          if (tx_bit == 3'd7) begin
            tx_state_next = TX_STOP;
            tx_line_next  = 1'b1;
          end else begin
            tx_bit_next   = tx_bit + 3'd1;
            tx_shift_next = {1'b0, tx_shift[7:1]};
            tx_line_next  = tx_shift[1];
          end
        end else begin
          tx_cnt_next = tx_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt <= 16'd1) begin
          tx_state_next = TX_IDLE;
          tx_line_next  = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt - 16'd1;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_line_next  = 1'b1;
      end
    endcase
  end

  assign uart_tx = tx_line;

  // ------------------------------------------------------- RX synchroniser
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_e   rx_state, rx_state_next;
  logic [15:0] rx_cnt, rx_cnt_next;
  logic [7:0]  rx_shift, rx_shift_next;
  logic [2:0]  rx_bit, rx_bit_next;
  logic        rx_done;
  logic        rx_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_shift <= rx_shift_next;
      rx_bit   <= rx_bit_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_shift_next = rx_shift;
    rx_bit_next   = rx_bit;
    rx_done       = 1'b0;
    rx_bad        = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_next = RX_START;
          rx_cnt_next   = {1'b0, divisor[15:1]};
        end
      end
      RX_START: begin
        if (rx_cnt <= 16'd1) begin
          if (!rx_sync) begin
            rx_state_next = RX_DATA;
            rx_cnt_next   = divisor;
            rx_bit_next   = '0;
          end else begin
            rx_state_next = RX_IDLE;
          end
        end else begin
          rx_cnt_next = rx_cnt - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt <= 16'd1) begin
          rx_shift_next = {rx_sync, rx_shift[7:1]};
          rx_cnt_next   = divisor;
          if (rx_bit == 3'd7) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_next = rx_cnt - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt <= 16'd1) begin
          if (rx_sync) begin
            rx_done       = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            rx_bad        = 1'b1;
            rx_state_next = RX_BREAK;
          end
        end else begin
          rx_cnt_next = rx_cnt - 16'd1;
        end
      end
      RX_BREAK: begin
        if (rx_sync) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // --------------------------------------------------------------- RX FIFO
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wptr;
  logic [AW:0] rx_rptr;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_pop;
  logic        rx_push;
  logic        rx_overrun_set;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign rx_pop   = rx_pop_req && !rx_empty;
  // A pop in the same cycle frees the slot the completed frame lands in.
  assign rx_push        = rx_done && (!rx_full || rx_pop);
  assign rx_overrun_set = rx_done && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  logic rx_overrun;
  logic rx_frame_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_overrun_set)    rx_overrun <= 1'b1;
      else if (sticky_clear) rx_overrun <= 1'b0;
      if (rx_bad)            rx_frame_err <= 1'b1;
      else if (sticky_clear) rx_frame_err <= 1'b0;
    end
  end

  // ------------------------------------------------------------- read port
  logic [15:0] rd_next;
  logic [15:0] rd_q;

  always_comb begin
    rd_next = '0;
    if (bus.register_read && in_window) begin
      case (offset)
        REG_STATUS:  rd_next = {10'd0, rx_frame_err, (tx_state != TX_IDLE), rx_overrun,
                                !rx_empty, tx_empty, tx_full};
        REG_RX_DATA: rd_next = rx_empty ? 16'd0 : {8'd0, rx_mem[rx_rptr[AW-1:0]]};
        REG_DIVISOR: rd_next = divisor;
        default:     rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_next;
  end

  assign bus.register_read_value = rd_q;

endmodule

// File: tb/tb_uart_peripheral.sv
// Randomised self-checking bench for uart_peripheral against a queue-based
// model of the register map, FIFOs and 8N1 framing.
module tb_uart_peripheral;
  localparam int unsigned BASE  = 40;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic uart_tx;
  logic uart_rx;

  uart_peripheral_if bus();

  uart_peripheral #(
    .BASE_INDEX  (BASE),
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic [7:0] rx_model[$];
  bit         m_overrun   = 1'b0;
  bit         m_frame_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input bit tx_full, input bit tx_empty, input bit tx_busy);
    return {10'd0, m_frame_err, tx_busy, m_overrun, (rx_model.size() != 0), tx_empty, tx_full};
  endfunction

  function automatic void model_rx(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                     m_frame_err = 1'b1;
    else if (rx_model.size() == DEPTH) m_overrun   = 1'b1;
    else                              rx_model.push_back(b);
  endfunction

  function automatic logic [6:0] ri(input int unsigned off);
    return 7'(BASE + off);
  endfunction

  task automatic reg_read(input logic [6:0] idx, output logic [15:0] val);
    @(negedge clk);
    bus.register_index = idx;
    bus.register_read  = 1'b1;
    @(posedge clk);
    #1 val = bus.register_read_value;
    bus.register_read = 1'b0;
  endtask

  task automatic reg_write(input logic [6:0] idx, input logic [15:0] val);
    @(negedge clk);
    bus.register_index       = idx;
    bus.register_write_value = val;
    bus.register_write       = 1'b1;
    @(negedge clk);
    bus.register_write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (div) @(negedge clk);
    end
  endtask

  // Waits (bounded) for a start bit, then samples every bit at its middle.
  task automatic capture_tx(input int div, output logic [7:0] b, output int t0, output bit ok);
    int   waited;
    logic start_bit;
    logic stop_bit;
    waited = 0;
    ok = 1'b0;
    b  = '0;
    t0 = 0;
    while (uart_tx !== 1'b0 && waited < 20 * div + 50) begin
      @(posedge clk);
      #1 waited++;
    end
    if (uart_tx === 1'b0) begin
      t0 = cyc;
      repeat (div / 2) @(posedge clk);
      #1 start_bit = uart_tx;
      for (int k = 0; k < 8; k++) begin
        repeat (div) @(posedge clk);
        #1 b[k] = uart_tx;
      end
      repeat (div) @(posedge clk);
      #1 stop_bit = uart_tx;
      ok = (start_bit === 1'b0) && (stop_bit === 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  b;
    logic [7:0]  got;
    logic [7:0]  got2;
    logic [7:0]  burst[10];
    logic [9:0]  fr;
    logic [39:0] wave;
    logic [39:0] exp_wave;
    int          t0;
    int          t1;
    int          t_prev;
    int          d;
    bit          ok;
    bit          ok2;

    reset_n                  = 1'b0;
    uart_rx                  = 1'b1;
    bus.register_index       = '0;
    bus.register_read        = 1'b0;
    bus.register_write       = 1'b0;
    bus.register_write_value = '0;
    repeat (3) @(negedge clk);
    check("reset_tx_idle", uart_tx, 1);
    check("reset_read_value", bus.register_read_value, 0);
    reset_n = 1'b1;

    // Register map basics
    reg_read(ri(0), v);
    check("status_reset", v, exp_status(0, 1, 0));
    reg_read(ri(4), v);
    check("divisor_reset", v, 16);
    @(posedge clk);
    #1 check("read_value_cleared", bus.register_read_value, 0);
    reg_write(7'(BASE - 4), 16'd9);
    reg_read(ri(4), v);
    check("divisor_write_outside", v, 16);
    reg_read(7'(BASE + 12), v);
    check("read_outside_window", v, 0);
    reg_write(ri(5), 16'hFFFF);
    reg_read(ri(5), v);
    check("offset5_reads_zero", v, 0);
    reg_write(ri(4), 16'd0);
    reg_read(ri(4), v);
    check("divisor_zero_clamp", v, 2);
    reg_write(ri(4), 16'd1);
    reg_read(ri(4), v);
    check("divisor_one_clamp", v, 2);
    reg_write(ri(4), 16'd4);
    reg_read(ri(4), v);
    check("divisor_four", v, 4);

    // Exact waveform of 0xA5 at 4 clocks/bit, line falling one edge after the write
    @(negedge clk);
    bus.register_index       = ri(1);
    bus.register_write_value = 16'h00A5;
    bus.register_write       = 1'b1;
    @(posedge clk);
    #1 bus.register_write = 1'b0;
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_wave[k*4+j] = fr[k];
        @(posedge clk);
        #1 wave[k*4+j] = uart_tx;
      end
    end
    check("tx_a5_wave", wave, exp_wave);
    @(posedge clk);
    #1 check("tx_after_frame_high", uart_tx, 1);

    reg_write(ri(1), 16'h005A);
    repeat (3) @(negedge clk);
    reg_read(ri(0), v);
    check("status_tx_busy", v, exp_status(0, 1, 1));
    repeat (45) @(negedge clk);
    reg_read(ri(0), v);
    check("status_tx_done", v, exp_status(0, 1, 0));

    // Random bytes at random divisors
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(2, 9);
      b = 8'($urandom);
      reg_write(ri(4), 16'(d));
      reg_write(ri(1), {8'd0, b});
      capture_tx(d, got, t0, ok);
      check("tx_rand_frame", ok, 1);
      check("tx_rand_byte", got, b);
      repeat (d + 2) @(negedge clk);
    end

    // Back-to-back burst: the first byte leaves the FIFO on the very next edge,
    // so DEPTH further bytes fit and the one after that is dropped.
    reg_write(ri(4), 16'd4);
    for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          bus.register_index       = ri(1);
          bus.register_write_value = {8'd0, burst[i]};
          bus.register_write       = 1'b1;
        end
        @(negedge clk);
        bus.register_write = 1'b0;
        reg_read(ri(0), v);
        check("status_tx_full", v, exp_status(1, 0, 1));
      end
      begin
        t_prev = 0;
        for (int i = 0; i <= int'(DEPTH); i++) begin
          capture_tx(4, got2, t1, ok2);
          check("burst_frame", ok2, 1);
          check("burst_byte", got2, burst[i]);
          if (i > 0) check("burst_spacing", t1 - t_prev, 41);
          t_prev = t1;
        end
      end
    join
    capture_tx(4, got, t0, ok);
    check("burst_overflow_dropped", ok, 0);
    reg_read(ri(0), v);
    check("status_after_burst", v, exp_status(0, 1, 0));

    // Single RX frame
    send_rx(8'h3C, 4, 1'b1);
    model_rx(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    reg_read(ri(0), v);
    check("status_rx_valid", v, exp_status(0, 1, 0));
    reg_read(ri(2), v);
    check("rx_data_3c", v, {8'd0, rx_model[0]});
    reg_write(ri(3), 16'd1);
    void'(rx_model.pop_front());
    reg_read(ri(0), v);
    check("status_rx_popped", v, exp_status(0, 1, 0));
    reg_read(ri(2), v);
    check("rx_data_empty", v, 0);

    // Nine random frames at random divisors with no pops
    for (int i = 0; i < 9; i++) begin
      d = $urandom_range(3, 10);
      b = 8'($urandom);
      reg_write(ri(4), 16'(d));
      send_rx(b, d, 1'b1);
      model_rx(b, 1'b1);
      repeat (2) @(negedge clk);
    end
    reg_read(ri(0), v);
    check("status_overrun", v, exp_status(0, 1, 0));
    for (int i = 0; i < int'(DEPTH); i++) begin
      reg_read(ri(2), v);
      check("rx_fifo_byte", v, {8'd0, rx_model[0]});
      reg_write(ri(3), (i == 0) ? 16'd3 : 16'd1);
      void'(rx_model.pop_front());
      if (i == 0) begin
        m_overrun = 1'b0;
        reg_read(ri(0), v);
        check("status_pop_and_clear", v, exp_status(0, 1, 0));
      end
    end
    reg_read(ri(0), v);
    check("status_rx_drained", v, exp_status(0, 1, 0));

    // Stop bit low, line then held low: frame error, no push, no new frame
    reg_write(ri(4), 16'd4);
    send_rx(8'h00, 4, 1'b0);
    model_rx(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    reg_read(ri(0), v);
    check("status_frame_err", v, exp_status(0, 1, 0));
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    reg_read(ri(0), v);
    check("status_after_break", v, exp_status(0, 1, 0));
    b = 8'($urandom);
    send_rx(b, 4, 1'b1);
    model_rx(b, 1'b1);
    repeat (3) @(negedge clk);
    reg_read(ri(2), v);
    check("rx_after_break", v, {8'd0, rx_model[0]});
    reg_write(ri(3), 16'd2);
    m_overrun   = 1'b0;
    m_frame_err = 1'b0;
    reg_read(ri(0), v);
    check("status_clear_only", v, exp_status(0, 1, 0));
    reg_write(ri(3), 16'd1);
    void'(rx_model.pop_front());
    reg_read(ri(0), v);
    check("status_final_rx", v, exp_status(0, 1, 0));

    // Asynchronous reset in the middle of a transmit
    reg_write(ri(4), 16'd8);
    for (int i = 0; i < 3; i++) reg_write(ri(1), 16'($urandom_range(0, 255)));
    repeat (3) @(posedge clk);
    #1 check("tx_low_before_reset", uart_tx, 0);
    #2 reset_n = 1'b0;
    #1 check("tx_async_reset", uart_tx, 1);
    rx_model.delete();
    m_overrun   = 1'b0;
    m_frame_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    reg_read(ri(0), v);
    check("status_after_reset", v, exp_status(0, 1, 0));
    reg_read(ri(4), v);
    check("divisor_after_reset", v, 16);
    capture_tx(16, got, t0, ok);
    check("tx_fifo_discarded", ok, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
